// File: rtl/execute_mdu_if.sv
// EX-stage bundle: ID/EX operands and controls in, results and the stall request out.
// The master side is the surrounding pipeline and the slave side is execute_mdu.
interface execute_mdu_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              flush;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              alu_src;
  logic              regdest;
  logic [1:0]        fwdA;
  logic [1:0]        fwdB;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] exmem_fwd;
  logic [DATA_W-1:0] memwb_fwd;
  logic [DATA_W-1:0] imm;
  logic [REG_W-1:0]  rt_addr;
  logic [REG_W-1:0]  rd_addr;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  write_reg;
  logic              zero;
  logic              ex_stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output in_valid, flush, alu_op, funct, alu_src, regdest, fwdA, fwdB,
           rs_data, rt_data, exmem_fwd, memwb_fwd, imm, rt_addr, rd_addr,
    input  alu_result, store_data, write_reg, zero, ex_stall, hi, lo
  );

  modport slave (
    input  in_valid, flush, alu_op, funct, alu_src, regdest, fwdA, fwdB,
           rs_data, rt_data, exmem_fwd, memwb_fwd, imm, rt_addr, rd_addr,
    output alu_result, store_data, write_reg, zero, ex_stall, hi, lo
  );
endinterface

// File: rtl/execute_mdu.sv
// MIPS EX stage: forwarding, ALU, destination mux, plus an iterative
// multiply/divide unit (one bit per cycle) that owns the HI/LO registers.
module execute_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic         clk,
  input logic         reset,
  execute_mdu_if.slave ex
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mduState_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_MFHI, ALU_MFLO, ALU_ZERO
  } aluCtl_t;

  mduState_t           state, stateNext;
  aluCtl_t             aluCtl;
  logic [DATA_W-1:0]   opA, opB, aluB, aluResult;
  logic [REG_W-1:0]    writeReg;
  logic                isMulDiv, start, exStall, doStep, lastStep;

  logic [2*DATA_W-1:0] acc, accNext;
  logic [DATA_W-1:0]   opnd, hiReg, loReg, hiFinal, loFinal;
  logic [CNT_W-1:0]    cnt;
  logic                divOp, negRes, negRem;
  logic                signedOp, aNeg, bNeg;
  logic [DATA_W-1:0]   magA, magB;
  logic [DATA_W:0]     mulSum, divDiff;
  logic [2*DATA_W-1:0] prodFinal;

  // Forwarding muxes; 11 falls back to the ID/EX value.
  always_comb begin
    unique case (ex.fwdA)
      2'b10:   opA = ex.exmem_fwd;
      2'b01:   opA = ex.memwb_fwd;
      default: opA = ex.rs_data;
    endcase
    unique case (ex.fwdB)
      2'b10:   opB = ex.exmem_fwd;
      2'b01:   opB = ex.memwb_fwd;
      default: opB = ex.rt_data;
    endcase
  end

  assign aluB     = ex.alu_src ? ex.imm : opB;
  assign writeReg = ex.regdest ? ex.rd_addr : ex.rt_addr;
  assign isMulDiv = (ex.alu_op == 2'b10) && (ex.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    aluCtl = ALU_ADD;
    unique case (ex.alu_op)
      2'b01: aluCtl = ALU_SUB;
      2'b10: begin
        unique case (ex.funct)
          6'h20, 6'h21: aluCtl = ALU_ADD;
          6'h22, 6'h23: aluCtl = ALU_SUB;
          6'h24:        aluCtl = ALU_AND;
          6'h25:        aluCtl = ALU_OR;
          6'h27:        aluCtl = ALU_NOR;
          6'h2A:        aluCtl = ALU_SLT;
          6'h2B:        aluCtl = ALU_SLTU;
          6'h10:        aluCtl = ALU_MFHI;
          6'h12:        aluCtl = ALU_MFLO;
          default:      aluCtl = ALU_ZERO;
        endcase
      end
      default: aluCtl = ALU_ADD;
    endcase
  end

  always_comb begin
    aluResult = '0;
    unique case (aluCtl)
      ALU_ADD:  aluResult = opA + aluB;
      ALU_SUB:  aluResult = opA - aluB;
      ALU_AND:  aluResult = opA & aluB;
      ALU_OR:   aluResult = opA | aluB;
      ALU_NOR:  aluResult = ~(opA | aluB);
      ALU_SLT:  aluResult = DATA_W'($signed(opA) < $signed(aluB));
      ALU_SLTU: aluResult = DATA_W'(opA < aluB);
      ALU_MFHI: aluResult = hiReg;
      ALU_MFLO: aluResult = loReg;
      default:  aluResult = '0;
    endcase
  end

  // Start is masked during reset so the stall drops the moment reset rises.
  assign start    = !reset && (state == IDLE) && ex.in_valid && isMulDiv;
  assign lastStep = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = BUSY;
      BUSY:    if (ex.flush) stateNext = IDLE;
               else if (lastStep) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    exStall = start || (state == BUSY);
    doStep  = (state == BUSY) && !ex.flush;
  end

  // Operands are reduced to magnitudes; funct[0] marks unsigned, funct[1] marks divide.
  assign signedOp = !ex.funct[0];
  assign aNeg     = signedOp && opA[DATA_W-1];
  assign bNeg     = signedOp && opB[DATA_W-1];
  assign magA     = aNeg ? -opA : opA;
  assign magB     = bNeg ? -opB : opB;

  // acc low half holds multiplier (mul) or dividend/quotient (div); high half is partial result.
  always_comb begin
    mulSum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    divDiff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};
    if (!divOp)             accNext = {mulSum, acc[DATA_W-1:1]};
    else if (!divDiff[DATA_W]) accNext = {divDiff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else                    accNext = {acc[2*DATA_W-2:0], 1'b0};
  end

  // A zero divisor leaves quotient all ones and remainder |dividend|; only the remainder sign is restored.
  always_comb begin
    prodFinal = negRes ? -accNext : accNext;
    if (divOp) begin
      loFinal = (negRes && (opnd != '0)) ? -accNext[DATA_W-1:0] : accNext[DATA_W-1:0];
      hiFinal = negRem ? -accNext[2*DATA_W-1:DATA_W] : accNext[2*DATA_W-1:DATA_W];
    end else begin
      loFinal = prodFinal[DATA_W-1:0];
      hiFinal = prodFinal[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      divOp  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      hiReg  <= '0;
      loReg  <= '0;
    end else if (start) begin
      acc    <= {{DATA_W{1'b0}}, magA};
      opnd   <= magB;
      cnt    <= '0;
      divOp  <= ex.funct[1];
      negRes <= aNeg ^ bNeg;
      negRem <= aNeg;
    end else if (doStep) begin
      acc <= accNext;
      cnt <= cnt + CNT_W'(1);
      if (lastStep) begin
        hiReg <= hiFinal;
        loReg <= loFinal;
      end
    end
  end

  assign ex.alu_result = aluResult;
  assign ex.store_data = opB;
  assign ex.write_reg  = writeReg;
  assign ex.zero       = (aluResult == '0);
  assign ex.ex_stall   = exStall;
  assign ex.hi         = hiReg;
  assign ex.lo         = loReg;
endmodule

// File: tb/tb_execute_mdu.sv
// Self-checking bench for execute_mdu: directed corner cases plus randomized ALU and
// mul/div traffic checked against a plain-arithmetic reference model.
module tb_execute_mdu;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;
  logic [DW-1:0] mHi = '0;
  logic [DW-1:0] mLo = '0;

  execute_mdu_if #(.DATA_W(DW), .REG_W(RW)) ex ();
  execute_mdu #(.DATA_W(DW), .REG_W(RW)) dut (.clk(clk), .reset(reset), .ex(ex));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] fwdVal(input logic [1:0] sel, input logic [DW-1:0] base,
                                           input logic [DW-1:0] exm, input logic [DW-1:0] mwb);
    if (sel == 2'b10) return exm;
    if (sel == 2'b01) return mwb;
    return base;
  endfunction

  function automatic logic [DW-1:0] refAlu(input logic [1:0] op, input logic [5:0] f,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h27: return ~(a | b);
      6'h2A: return (int'(a) < int'(b)) ? 1 : 0;
      6'h2B: return (a < b) ? 1 : 0;
      6'h10: return mHi;
      6'h12: return mLo;
      default: return '0;
    endcase
  endfunction

  task automatic refMulDiv(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] eh, output logic [DW-1:0] el);
    longint p;
    longint unsigned pu;
    int sa, sb;
    sa = a;
    sb = b;
    eh = '0;
    el = '0;
    case (f)
      6'h18: begin p = longint'(sa) * longint'(sb); {eh, el} = p; end
      6'h19: begin pu = {32'd0, a} * {32'd0, b}; {eh, el} = pu; end
      6'h1A: begin
        if (b == 0) begin el = '1; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = '0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin el = '1; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  task automatic idleInputs();
    ex.in_valid = 0; ex.flush = 0; ex.alu_op = 0; ex.funct = 0;
    ex.alu_src = 0; ex.regdest = 0; ex.fwdA = 0; ex.fwdB = 0;
    ex.rs_data = 0; ex.rt_data = 0; ex.exmem_fwd = 0; ex.memwb_fwd = 0;
    ex.imm = 0; ex.rt_addr = 0; ex.rd_addr = 0;
  endtask

  // Place operands behind random, non-conflicting forwarding selects.
  task automatic driveMulDiv(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int r;
    ex.in_valid = 1; ex.flush = 0; ex.alu_op = 2'b10; ex.funct = f; ex.alu_src = 0;
    ex.rs_data = $urandom; ex.rt_data = $urandom; ex.exmem_fwd = $urandom;
    ex.memwb_fwd = $urandom; ex.imm = $urandom;
    r = $urandom_range(0, 2);
    ex.fwdA = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
    ex.fwdB = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
    if (ex.fwdA == 2'b10) ex.exmem_fwd = a; else ex.rs_data = a;
    if (ex.fwdB == 2'b01) ex.memwb_fwd = b; else ex.rt_data = b;
  endtask

  // Holds the instruction while the stall is high; returns in the DONE cycle.
  task automatic runMulDiv(input string tag, input logic [5:0] f,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    int stalls;
    logic [DW-1:0] eh, el;
    @(negedge clk);
    driveMulDiv(f, a, b);
    #1;
    check({tag, " start result"}, ex.alu_result, 0);
    stalls = 0;
    while (ex.ex_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall cycles"}, stalls, DW + 1);
    refMulDiv(f, a, b, eh, el);
    mHi = eh;
    mLo = el;
    check({tag, " hi"}, ex.hi, mHi);
    check({tag, " lo"}, ex.lo, mLo);
  endtask

  task automatic combCheck(input string tag);
    logic [DW-1:0] a, b, bs, exp;
    #1;
    a   = fwdVal(ex.fwdA, ex.rs_data, ex.exmem_fwd, ex.memwb_fwd);
    bs  = fwdVal(ex.fwdB, ex.rt_data, ex.exmem_fwd, ex.memwb_fwd);
    b   = ex.alu_src ? ex.imm : bs;
    exp = refAlu(ex.alu_op, ex.funct, a, b);
    check({tag, " result"}, ex.alu_result, exp);
    check({tag, " zero"}, ex.zero, exp == 0);
    check({tag, " store"}, ex.store_data, bs);
    check({tag, " wreg"}, ex.write_reg, ex.regdest ? ex.rd_addr : ex.rt_addr);
  endtask

  logic [5:0] functs [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                              6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F, 6'h00};
  logic [5:0] mdFuncts [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  initial begin
    idleInputs();
    // A MULT sits on the inputs during reset: it must not stall, and comb paths still work.
    ex.in_valid = 1; ex.alu_op = 2'b10; ex.funct = 6'h18; ex.rs_data = 5; ex.rt_data = 7;
    #1;
    check("reset stall", ex.ex_stall, 0);
    check("reset hi", ex.hi, 0);
    check("reset lo", ex.lo, 0);
    ex.funct = 6'h20;
    combCheck("reset comb");
    repeat (2) @(negedge clk);
    ex.in_valid = 0;
    reset = 0;

    // Forwarded subtract.
    @(negedge clk);
    idleInputs();
    ex.fwdA = 2'b10; ex.exmem_fwd = 5; ex.rs_data = 99; ex.rt_data = 3;
    ex.alu_op = 2'b10; ex.funct = 6'h22;
    #1;
    check("fwd sub result", ex.alu_result, 2);
    check("fwd sub zero", ex.zero, 0);

    // slt / sltu / immediate add wrap.
    ex.fwdA = 0; ex.rs_data = 32'h8000_0000; ex.rt_data = 1; ex.funct = 6'h2A;
    #1; check("slt", ex.alu_result, 1);
    ex.funct = 6'h2B;
    #1; check("sltu", ex.alu_result, 0);
    ex.alu_op = 2'b00; ex.alu_src = 1; ex.imm = 32'hFFFF_FFFF; ex.rs_data = 1;
    #1;
    check("addi wrap", ex.alu_result, 0);
    check("addi zero", ex.zero, 1);

    // MULT then MFLO/MFHI in the following cycle.
    runMulDiv("mult neg", 6'h18, 32'hFFFF_FFFE, 3);
    check("mult hi const", ex.hi, 32'hFFFF_FFFF);
    check("mult lo const", ex.lo, 32'hFFFF_FFFA);
    @(negedge clk);
    idleInputs();
    ex.in_valid = 1; ex.alu_op = 2'b10; ex.funct = 6'h12;
    #1;
    check("mflo", ex.alu_result, 32'hFFFF_FFFA);
    check("mflo stall", ex.ex_stall, 0);
    ex.funct = 6'h10;
    #1; check("mfhi", ex.alu_result, 32'hFFFF_FFFF);

    runMulDiv("div neg", 6'h1A, 32'hFFFF_FFF9, 2);
    check("div lo const", ex.lo, 32'hFFFF_FFFD);
    check("div hi const", ex.hi, 32'hFFFF_FFFF);
    runMulDiv("divu by0", 6'h1B, 10, 0);
    check("divu0 lo const", ex.lo, 32'hFFFF_FFFF);
    check("divu0 hi const", ex.hi, 10);
    runMulDiv("div min", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    runMulDiv("div by0", 6'h1A, 32'hFFFF_FFF9, 0);

    // Held MULTU: after DONE the pipeline advances, no second operation may start.
    runMulDiv("multu held", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ex.in_valid = 0;
      #1;
      check("held no restart", ex.ex_stall, 0);
    end
    check("held hi", ex.hi, mHi);

    // Back-to-back multiplies.
    runMulDiv("b2b 1", 6'h18, 32'd123456, 32'hFFFF_0000);
    runMulDiv("b2b 2", 6'h18, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Asynchronous reset ten cycles into a DIV.
    @(negedge clk);
    driveMulDiv(6'h1A, 1000, 7);
    repeat (10) @(negedge clk);
    #2 reset = 1;
    #1;
    check("async rst stall", ex.ex_stall, 0);
    check("async rst hi", ex.hi, 0);
    check("async rst lo", ex.lo, 0);
    mHi = 0;
    mLo = 0;
    ex.in_valid = 0;
    @(negedge clk);
    reset = 0;

    // Flush in BUSY keeps the previous HI/LO.
    runMulDiv("pre flush", 6'h19, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    driveMulDiv(6'h1B, 32'hFFFF_FFFF, 3);
    repeat (6) @(negedge clk);
    ex.flush = 1;
    ex.in_valid = 0;
    @(negedge clk);
    ex.flush = 0;
    #1;
    check("flush stall", ex.ex_stall, 0);
    repeat (DW + 4) @(negedge clk);
    check("flush hi", ex.hi, mHi);
    check("flush lo", ex.lo, mLo);

    // Randomized mul/div including forced corner operands.
    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(0, 15);
      if (i % 6 == 2) b = 0;
      if (i % 5 == 3) a = 32'h8000_0000;
      runMulDiv($sformatf("rand md %0d", i), mdFuncts[$urandom_range(0, 3)], a, b);
    end

    // Randomized ALU traffic with no start possible.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ex.in_valid = 0; ex.flush = 0;
      ex.alu_op = 2'($urandom_range(0, 3));
      ex.funct = functs[$urandom_range(0, 16)];
      ex.alu_src = 1'($urandom_range(0, 1));
      ex.regdest = 1'($urandom_range(0, 1));
      ex.fwdA = 2'($urandom_range(0, 3));
      ex.fwdB = 2'($urandom_range(0, 3));
      ex.rs_data = $urandom; ex.rt_data = $urandom; ex.exmem_fwd = $urandom;
      ex.memwb_fwd = $urandom; ex.imm = $urandom;
      ex.rt_addr = 5'($urandom); ex.rd_addr = 5'($urandom);
      if (i % 5 == 0) ex.rt_data = ex.rs_data;
      combCheck($sformatf("rand alu %0d", i));
      check("rand alu stall", ex.ex_stall, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
